engine_stride_index_multichannel: RTL and testbench

Parametrised successor of the single-lane stride index generator. It accepts one stride-index configuration and generates the index sequence from index_start towards index_end in steps of stride, incrementing or decrementing. Indices are dealt round-robin to NUM_CHANNELS Vertex-CU lanes in batches of granularity, and each lane has its own output FIFO so one slow CU only stalls the generator. It sits between the CU setup/control layer and the per-CU read engines.

---
 rtl/engine_stride_index_multichannel_pkg.sv | 47 ++++
 rtl/engine_stride_index_multichannel_if.sv | 45 ++++
 rtl/engine_stride_index_lane_fifo.sv | 81 ++++++++
 rtl/engine_stride_index_multichannel.sv | 183 ++++++++++++++++++
 tb/tb_engine_stride_index_multichannel.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/engine_stride_index_multichannel_pkg.sv
// Shared types for the multi-lane stride index engine: configuration, payload,
// per-index meta and the generator FSM state encoding.
package engine_stride_index_multichannel_pkg;

  localparam int M_AXI_MEMORY_ADDR_WIDTH = 32;
  localparam int MAX_CHANNELS            = 16;

  typedef struct packed {
    logic [7:0] id_cu;
    logic [3:0] id_bundle;
    logic [3:0] cmd;
  } MemoryPacketMeta;

  typedef struct packed {
    logic                               increment;
    logic                               decrement;
    logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index_start;
    logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index_end;
    logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] stride;
    logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] granularity;
    // Reserved for lane masking; the engine always deals to every lane.
    logic [$clog2(MAX_CHANNELS):0]      num_channels_active;
  } StrideIndexMultiChannelConfigurationParameters;

  typedef struct packed {
    StrideIndexMultiChannelConfigurationParameters param;
    MemoryPacketMeta                               meta;
  } StrideIndexMultiChannelConfiguration;

  typedef struct packed {
    logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index;
    MemoryPacketMeta                    meta;
    logic                               last;
  } StrideIndexMultiChannelPayload;

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_SETUP,
    S_START,
    S_BUSY,
    S_PAUSE,
    S_DRAIN,
    S_DONE
  } engine_stride_index_multichannel_state;

endpackage

// File: rtl/engine_stride_index_multichannel_if.sv
// Configuration, per-lane output and status bundle of the stride index engine.
// slave is the engine side, master the control/CU side.
interface engine_stride_index_multichannel_if
  import engine_stride_index_multichannel_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int INDEX_W      = M_AXI_MEMORY_ADDR_WIDTH,
  parameter int META_W       = $bits(MemoryPacketMeta)
) ();

  logic                             cfg_valid;
  logic                             cfg_ready;
  logic                             cfg_increment;
  logic                             cfg_decrement;
  logic [INDEX_W-1:0]               cfg_index_start;
  logic [INDEX_W-1:0]               cfg_index_end;
  logic [INDEX_W-1:0]               cfg_stride;
  logic [INDEX_W-1:0]               cfg_granularity;
  logic [META_W-1:0]                cfg_meta;
  logic                             pause_in;
  logic [NUM_CHANNELS-1:0]          out_valid;
  logic [NUM_CHANNELS-1:0]          out_ready;
  logic [NUM_CHANNELS*INDEX_W-1:0]  out_index;
  logic [NUM_CHANNELS*META_W-1:0]   out_meta;
  logic [NUM_CHANNELS-1:0]          out_last;
  logic                             busy_out;
  logic                             done_out;
  logic                             error_out;
  logic [INDEX_W-1:0]               issued_count;

  modport slave (
    input  cfg_valid, cfg_increment, cfg_decrement, cfg_index_start, cfg_index_end,
           cfg_stride, cfg_granularity, cfg_meta, pause_in, out_ready,
    output cfg_ready, out_valid, out_index, out_meta, out_last,
           busy_out, done_out, error_out, issued_count
  );

  modport master (
    output cfg_valid, cfg_increment, cfg_decrement, cfg_index_start, cfg_index_end,
           cfg_stride, cfg_granularity, cfg_meta, pause_in, out_ready,
    input  cfg_ready, out_valid, out_index, out_meta, out_last,
           busy_out, done_out, error_out, issued_count
  );

endinterface

// File: rtl/engine_stride_index_lane_fifo.sv
// Per-lane output FIFO: array storage with a registered head stage, so the head
// entry is presented from a flop and an empty FIFO forwards a write in one cycle.
module engine_stride_index_lane_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   mem_cnt_reg;
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_data_reg;

  logic pop, load_head, mem_has, wr_ok, bypass, mem_wr, mem_rd;

  assign pop       = head_valid_reg & rd_en;
  assign load_head = ~head_valid_reg | pop;
  assign mem_has   = (mem_cnt_reg != '0);
  // The head flop counts toward capacity, so the array never exceeds DEPTH-1.
  assign full      = head_valid_reg & (mem_cnt_reg == (PTR_W+1)'(DEPTH - 1));
  assign empty     = ~head_valid_reg & ~mem_has;
  assign wr_ok     = wr_en & (~full | pop);
  assign mem_rd    = load_head & mem_has;
  assign bypass    = load_head & ~mem_has & wr_ok;
  assign mem_wr    = wr_ok & ~bypass;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_cnt_reg    <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (mem_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt_reg <= mem_cnt_reg + (PTR_W+1)'(1);
        2'b01:   mem_cnt_reg <= mem_cnt_reg - (PTR_W+1)'(1);
        default: mem_cnt_reg <= mem_cnt_reg;
      endcase
      if (load_head) begin
        if (mem_has) begin
          head_data_reg  <= mem[rd_ptr_reg];
          head_valid_reg <= 1'b1;
        end else if (bypass) begin
          head_data_reg  <= wr_data;
          head_valid_reg <= 1'b1;
        end else begin
          head_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign rd_valid = head_valid_reg;
  assign rd_data  = head_data_reg;

endmodule

// File: rtl/engine_stride_index_multichannel.sv
// Stride index generator dealing indices round-robin, in batches of granularity,
// to NUM_CHANNELS lanes, each buffered by its own output FIFO.
module engine_stride_index_multichannel
  import engine_stride_index_multichannel_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int INDEX_W      = M_AXI_MEMORY_ADDR_WIDTH,
  parameter int META_W       = $bits(MemoryPacketMeta),
  parameter int FIFO_DEPTH   = 16
) (
  input logic                               ap_clk,
  input logic                               ap_rst_n,
  engine_stride_index_multichannel_if.slave bus
);

  localparam int LANE_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int ENTRY_W = INDEX_W + META_W + 1;

  engine_stride_index_multichannel_state state_reg, state_next;

  logic               inc_reg, dec_reg, error_reg, done_reg;
  logic [INDEX_W-1:0] start_reg, end_reg, stride_reg, gran_reg;
  logic [INDEX_W-1:0] cur_reg, batch_reg, issued_reg;
  logic [META_W-1:0]  meta_reg;
  logic [LANE_W-1:0]  lane_reg;

  logic               cfg_fire, cfg_illegal, in_range, next_in_range, last_flag;
  logic               lane_blocked, write_fire, cfg_ready_int, busy_int;
  logic [INDEX_W:0]   next_wide;
  logic [INDEX_W-1:0] batch_inc;
  logic [LANE_W-1:0]  lane_inc;

  logic [NUM_CHANNELS-1:0] fifo_full, fifo_empty, fifo_valid, fifo_pop, fifo_wr;
  logic [ENTRY_W-1:0]      fifo_dout [NUM_CHANNELS];

  assign cfg_fire    = bus.cfg_valid & cfg_ready_int;
  assign cfg_illegal = (inc_reg == dec_reg) | (stride_reg == '0);
  assign in_range    = inc_reg ? (cur_reg < end_reg) : (cur_reg > end_reg);

  // One extra bit catches carry (ascending) or borrow (descending) past the index range.
  assign next_wide     = inc_reg ? ({1'b0, cur_reg} + {1'b0, stride_reg})
                                 : ({1'b0, cur_reg} - {1'b0, stride_reg});
  assign next_in_range = inc_reg ? (next_wide[INDEX_W-1:0] < end_reg)
                                 : (next_wide[INDEX_W-1:0] > end_reg);
  assign last_flag     = next_wide[INDEX_W] | ~next_in_range;

  // A full lane that is being drained this cycle still accepts the write.
  assign lane_blocked = bus.pause_in | (fifo_full[lane_reg] & ~fifo_pop[lane_reg]);
  assign batch_inc    = batch_reg + INDEX_W'(1);
  assign lane_inc     = (lane_reg == LANE_W'(NUM_CHANNELS - 1)) ? '0 : lane_reg + LANE_W'(1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg <= S_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: state_next = S_IDLE;
      S_IDLE:  if (cfg_fire) state_next = S_SETUP;
      S_SETUP: state_next = cfg_illegal ? S_DONE : S_START;
      S_START: state_next = S_BUSY;
      S_BUSY: begin
        if (!in_range) begin
          state_next = S_DRAIN;
        end else if (lane_blocked) begin
          state_next = S_PAUSE;
        end else if (last_flag) begin
          state_next = S_DRAIN;
        end
      end
      S_PAUSE: if (!lane_blocked) state_next = S_BUSY;
      S_DRAIN: if (&fifo_empty) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    cfg_ready_int = 1'b0;
    busy_int      = 1'b0;
    write_fire    = 1'b0;
    case (state_reg)
      S_IDLE:                    cfg_ready_int = 1'b1;
      S_SETUP, S_START, S_PAUSE,
      S_DRAIN:                   busy_int      = 1'b1;
      S_BUSY: begin
        busy_int   = 1'b1;
        write_fire = in_range & ~lane_blocked;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      inc_reg    <= 1'b0;
      dec_reg    <= 1'b0;
      start_reg  <= '0;
      end_reg    <= '0;
      stride_reg <= '0;
      gran_reg   <= '0;
      meta_reg   <= '0;
      cur_reg    <= '0;
      batch_reg  <= '0;
      lane_reg   <= '0;
      issued_reg <= '0;
      error_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_DONE);
      if (cfg_fire) begin
        inc_reg    <= bus.cfg_increment;
        dec_reg    <= bus.cfg_decrement;
        start_reg  <= bus.cfg_index_start;
        end_reg    <= bus.cfg_index_end;
        stride_reg <= bus.cfg_stride;
        gran_reg   <= bus.cfg_granularity;
        meta_reg   <= bus.cfg_meta;
        issued_reg <= '0;
        error_reg  <= 1'b0;
      end
      if (state_reg == S_SETUP) begin
        if (cfg_illegal) error_reg <= 1'b1;
        if (gran_reg == '0) gran_reg <= INDEX_W'(1);
      end
      if (state_reg == S_START) begin
        cur_reg   <= start_reg;
        lane_reg  <= '0;
        batch_reg <= '0;
      end
      if (write_fire) begin
        cur_reg    <= next_wide[INDEX_W-1:0];
        issued_reg <= issued_reg + INDEX_W'(1);
        if (batch_inc == gran_reg) begin
          batch_reg <= '0;
          lane_reg  <= lane_inc;
        end else begin
          batch_reg <= batch_inc;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
      assign fifo_wr[gi]  = write_fire & (lane_reg == LANE_W'(gi));
      assign fifo_pop[gi] = fifo_valid[gi] & bus.out_ready[gi];

      engine_stride_index_lane_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .wr_en    (fifo_wr[gi]),
        .wr_data  ({cur_reg, meta_reg, last_flag}),
        .rd_en    (bus.out_ready[gi]),
        .rd_valid (fifo_valid[gi]),
        .rd_data  (fifo_dout[gi]),
        .full     (fifo_full[gi]),
        .empty    (fifo_empty[gi])
      );

      assign bus.out_valid[gi]                    = fifo_valid[gi];
      assign bus.out_index[gi*INDEX_W +: INDEX_W] = fifo_dout[gi][ENTRY_W-1 -: INDEX_W];
      assign bus.out_meta[gi*META_W +: META_W]    = fifo_dout[gi][META_W:1];
      // The head flop keeps stale data after a pop; last must not outlive valid.
      assign bus.out_last[gi]                     = fifo_valid[gi] & fifo_dout[gi][0];
    end
  endgenerate

  assign bus.cfg_ready    = cfg_ready_int;
  assign bus.busy_out     = busy_int;
  assign bus.done_out     = done_reg;
  assign bus.error_out    = error_reg;
  assign bus.issued_count = issued_reg;

endmodule

// File: tb/tb_engine_stride_index_multichannel.sv
// Scoreboard bench: directed configs push hand-computed per-lane expectations,
// a negedge monitor pops and compares every accepted output.
module tb_engine_stride_index_multichannel;
  import engine_stride_index_multichannel_pkg::*;

  localparam int NC    = 4;
  localparam int IW    = 32;
  localparam int MW    = $bits(MemoryPacketMeta);
  localparam int DEPTH = 16;
  localparam int EW    = IW + MW + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  engine_stride_index_multichannel_if #(.NUM_CHANNELS(NC), .INDEX_W(IW), .META_W(MW)) bus ();

  engine_stride_index_multichannel #(
    .NUM_CHANNELS (NC),
    .INDEX_W      (IW),
    .META_W       (MW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  logic [MW-1:0] cur_meta;
  logic [EW-1:0] exp_q [NC][$];
  logic [NC-1:0] stall_prev = '0;
  logic [EW-1:0] data_prev [NC];

  // Test 1 expected indices, lane-major: lane = position / 4.
  int t1 [16] = '{0, 1, 8, 9, 2, 3, 10, 11, 4, 5, 12, 13, 6, 7, 14, 15};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idx(input int lane, input logic [IW-1:0] idx, input logic last);
    exp_q[lane].push_back({idx, cur_meta, last});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = '0;
    end else begin
      if (bus.done_out) done_seen++;
      for (int l = 0; l < NC; l++) begin
        logic [EW-1:0] w;
        w = {bus.out_index[l*IW +: IW], bus.out_meta[l*MW +: MW], bus.out_last[l]};
        if (stall_prev[l])
          check($sformatf("hold_lane%0d", l), {bus.out_valid[l], w}, {1'b1, data_prev[l]});
        if (bus.out_valid[l] && bus.out_ready[l]) begin
          if (exp_q[l].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_lane%0d actual=%0h required=none", l, w);
          end else begin
            check($sformatf("data_lane%0d", l), w, exp_q[l].pop_front());
          end
        end
        stall_prev[l] = bus.out_valid[l] & ~bus.out_ready[l];
        data_prev[l]  = w;
      end
    end
  end

  task automatic issue(input logic inc, input logic dec, input logic [IW-1:0] start,
                       input logic [IW-1:0] stop, input logic [IW-1:0] stride,
                       input logic [IW-1:0] gran);
    int k;
    k = 0;
    while (!bus.cfg_ready && k < 20) begin
      tick();
      k++;
    end
    check("cfg_ready_at_issue", bus.cfg_ready, 1);
    bus.cfg_valid       = 1'b1;
    bus.cfg_increment   = inc;
    bus.cfg_decrement   = dec;
    bus.cfg_index_start = start;
    bus.cfg_index_end   = stop;
    bus.cfg_stride      = stride;
    bus.cfg_granularity = gran;
    bus.cfg_meta        = cur_meta;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  // Cycle numbers count the handshake cycle as cycle 0.
  task automatic wait_done(input string tag, input int exp_issued, input logic exp_err,
                           input int first_cycle_exp, input int done_cycle_exp,
                           input int release_at, input int issued_at_release, input bit do_pause);
    int d0, first_cycle, done_cycle;
    bit got, saw_valid;
    d0 = done_seen;
    first_cycle = -1;
    done_cycle = -1;
    got = 0;
    saw_valid = 0;
    for (int k = 1; k <= 3000 && !got; k++) begin
      bus.pause_in = do_pause && (k >= 5) && (k < 10);
      if (release_at == k) begin
        check({tag, "_issued_while_held"}, bus.issued_count, issued_at_release);
        bus.out_ready = '1;
      end
      tick();
      if (bus.out_valid != '0) begin
        saw_valid = 1;
        if (first_cycle < 0) first_cycle = k + 1;
      end
      if (bus.done_out) begin
        got = 1;
        done_cycle = k + 1;
      end
    end
    bus.pause_in = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_done_timeout actual=none required=done_out", tag);
    end
    if (first_cycle_exp > 0) check({tag, "_first_valid_cycle"}, first_cycle, first_cycle_exp);
    if (done_cycle_exp > 0) check({tag, "_done_cycle"}, done_cycle, done_cycle_exp);
    if (exp_err) check({tag, "_no_output"}, saw_valid, 0);
    check({tag, "_issued"}, bus.issued_count, exp_issued);
    check({tag, "_error"}, bus.error_out, exp_err);
    tick();
    tick();
    check({tag, "_done_pulses"}, done_seen - d0, 1);
    check({tag, "_busy_after"}, bus.busy_out, 0);
    for (int l = 0; l < NC; l++)
      check($sformatf("%s_pending_lane%0d", tag, l), exp_q[l].size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int d0;
    bus.cfg_valid       = 1'b0;
    bus.cfg_increment   = 1'b0;
    bus.cfg_decrement   = 1'b0;
    bus.cfg_index_start = '0;
    bus.cfg_index_end   = '0;
    bus.cfg_stride      = '0;
    bus.cfg_granularity = '0;
    bus.cfg_meta        = '0;
    bus.pause_in        = 1'b0;
    bus.out_ready       = '1;
    cur_meta            = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_done", bus.done_out, 0);
    check("rst_issued", bus.issued_count, 0);
    rst_n = 1'b1;
    check("release_cfg_ready", bus.cfg_ready, 0);
    tick();
    tick();
    check("idle_cfg_ready", bus.cfg_ready, 1);

    // Ascending, granularity 2 across four lanes.
    cur_meta = 16'hA101;
    for (int i = 0; i < 16; i++) expect_idx(i / 4, t1[i], t1[i] == 15);
    issue(1, 0, 0, 16, 1, 2);
    wait_done("incr_gran2", 16, 0, 4, 0, 0, 0, 0);
    $display("txn incr_gran2 done total=%0d bad=%0d", total, bad);

    // Same sequence with an external pause window.
    cur_meta = 16'hB202;
    for (int i = 0; i < 16; i++) expect_idx(i / 4, t1[i], t1[i] == 15);
    issue(1, 0, 0, 16, 1, 2);
    wait_done("incr_paused", 16, 0, 4, 0, 0, 0, 1);
    $display("txn incr_paused done total=%0d bad=%0d", total, bad);

    // Descending, stops before borrowing below zero.
    cur_meta = 16'hC303;
    expect_idx(0, 10, 0);
    expect_idx(1, 7, 0);
    expect_idx(2, 4, 0);
    expect_idx(3, 1, 1);
    issue(0, 1, 10, 0, 3, 1);
    wait_done("decr_s3", 4, 0, 4, 0, 0, 0, 0);
    $display("txn decr_s3 done total=%0d bad=%0d", total, bad);

    // Carry out of the index width terminates the sequence.
    cur_meta = 16'hD404;
    expect_idx(0, 32'hFFFF_FFF0, 0);
    expect_idx(1, 32'hFFFF_FFF8, 1);
    issue(1, 0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 8, 1);
    wait_done("incr_carry", 2, 0, 4, 0, 0, 0, 0);
    $display("txn incr_carry done total=%0d bad=%0d", total, bad);

    // Zero-length sequence.
    cur_meta = 16'hE505;
    issue(1, 0, 5, 5, 1, 1);
    wait_done("zero_len", 0, 0, 0, 0, 0, 0, 0);
    $display("txn zero_len done total=%0d bad=%0d", total, bad);

    // Illegal configurations.
    cur_meta = 16'hF606;
    issue(1, 1, 0, 16, 1, 1);
    wait_done("err_both_modes", 0, 1, 0, 3, 0, 0, 0);
    $display("txn err_both_modes done total=%0d bad=%0d", total, bad);
    issue(1, 0, 0, 16, 0, 1);
    wait_done("err_stride0", 0, 1, 0, 3, 0, 0, 0);
    $display("txn err_stride0 done total=%0d bad=%0d", total, bad);

    // Legal config after an error; granularity 0 acts as 1.
    cur_meta = 16'h1707;
    expect_idx(0, 0, 0);
    expect_idx(1, 1, 0);
    expect_idx(2, 2, 0);
    expect_idx(3, 3, 0);
    expect_idx(0, 4, 0);
    expect_idx(1, 5, 0);
    expect_idx(2, 6, 1);
    issue(1, 0, 0, 7, 1, 0);
    wait_done("gran0_clear_err", 7, 0, 4, 0, 0, 0, 0);
    $display("txn gran0_clear_err done total=%0d bad=%0d", total, bad);

    // Lane 1 held: FIFO1 fills with 1,5,..,61, generator stalls after 64.
    cur_meta = 16'h2808;
    for (int i = 0; i < 256; i++) expect_idx(i % 4, i, i == 255);
    bus.out_ready = 4'b1101;
    issue(1, 0, 0, 256, 1, 1);
    wait_done("hold_lane1", 256, 0, 4, 0, 200, 65, 0);
    $display("txn hold_lane1 done total=%0d bad=%0d", total, bad);

    // Reset in the middle of a run with FIFOs partly full.
    cur_meta = 16'h3909;
    bus.out_ready = '0;
    d0 = done_seen;
    issue(1, 0, 0, 100, 1, 1);
    repeat (12) tick();
    check("pre_reset_issued", bus.issued_count, 10);
    check("pre_reset_valid", bus.out_valid, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_last", bus.out_last, 0);
    check("mid_rst_index", bus.out_index, 0);
    check("mid_rst_busy", bus.busy_out, 0);
    check("mid_rst_issued", bus.issued_count, 0);
    check("mid_rst_cfg_ready", bus.cfg_ready, 0);
    bus.out_ready = '1;
    repeat (2) tick();
    rst_n = 1'b1;
    check("post_rst_cfg_ready_low", bus.cfg_ready, 0);
    tick();
    tick();
    check("post_rst_cfg_ready", bus.cfg_ready, 1);
    repeat (4) tick();
    check("post_rst_no_done", done_seen - d0, 0);
    $display("txn mid_reset done total=%0d bad=%0d", total, bad);

    // Recovery run after reset.
    cur_meta = 16'h4A0A;
    expect_idx(0, 5, 0);
    expect_idx(1, 3, 0);
    expect_idx(2, 1, 1);
    issue(0, 1, 5, 0, 2, 1);
    wait_done("recover_decr", 3, 0, 4, 0, 0, 0, 0);
    $display("txn recover_decr done total=%0d bad=%0d", total, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
